memory_arbiter: RTL and testbench

Two-port arbiter that shares the single Hack data-memory port (RAM16K + screen + keyboard, 15-bit address, 16-bit data) between requester A (CPU data side) and requester B (screen/DMA engine). Each cycle it grants at most one requester, which drives the memory's `in`/`load`/`address`. On contention it alternates between requesters (round-robin), and supports bounded locked bursts. Read data is registered and returned one cycle after the grant.

---
 rtl/memory_arbiter_if.sv | 44 ++++
 rtl/memory_arbiter.sv | 136 +++++++++++++
 tb/tb_memory_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Shared Hack data-memory bus: two requester ports plus the single memory port.
// The arbiter connects through the slave modport; requesters and memory use master.
interface memory_arbiter_if;
  logic        a_req;
  logic        a_we;
  logic        a_lock;
  logic [14:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic [15:0] a_rdata;

  logic        b_req;
  logic        b_we;
  logic        b_lock;
  logic [14:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_gnt;
  logic        b_rvalid;
  logic [15:0] b_rdata;

  logic [15:0] mem_in;
  logic        mem_load;
  logic [14:0] mem_addr;
  logic [15:0] mem_out;

  modport slave (
    input  a_req, a_we, a_lock, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_lock, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_in, mem_load, mem_addr,
    input  mem_out
  );

  modport master (
    output a_req, a_we, a_lock, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_lock, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_in, mem_load, mem_addr,
    output mem_out
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter for the Hack data-memory port with bounded locked bursts.
// Grants are combinational; read data returns registered one cycle after the grant.
//
// state | meaning
// ARB   | no lock held, contention resolved against last winner
// OWN_A | A holds a locked burst, B waits while A keeps requesting
// OWN_B | B holds a locked burst, A waits while B keeps requesting
module memory_arbiter #(
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  memory_arbiter_if.slave  bus
);

  localparam int CW      = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam bit LOCK_EN = (MAX_BURST > 1);

  typedef enum logic [1:0] {ARB, OWN_A, OWN_B} state_t;

  state_t        state;
  logic          last;      // 0 = A won last grant, 1 = B
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          gnt_a;
  logic          gnt_b;
  logic [14:0]   sel_addr;
  logic [15:0]   sel_wdata;
  logic          sel_we;
  logic          a_rvalid_q;
  logic          b_rvalid_q;
  logic [15:0]   a_rdata_q;
  logic [15:0]   b_rdata_q;

  assign cnt_inc = cnt + CW'(1);

  // An owner that stops requesting releases its lock in the same cycle,
  // so that cycle falls through to normal arbitration.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (state == OWN_A && bus.a_req) begin
        gnt_a = 1'b1;
      end else if (state == OWN_B && bus.b_req) begin
        gnt_b = 1'b1;
      end else if (bus.a_req && bus.b_req) begin
        gnt_a = last;
        gnt_b = ~last;
      end else begin
        gnt_a = bus.a_req;
        gnt_b = bus.b_req;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (gnt_a) begin
      sel_addr  = bus.a_addr;
      sel_wdata = bus.a_wdata;
      sel_we    = bus.a_we;
    end else if (gnt_b) begin
      sel_addr  = bus.b_addr;
      sel_wdata = bus.b_wdata;
      sel_we    = bus.b_we;
    end
  end

  // Keyboard region is read-only: the write is granted but never reaches memory.
  assign bus.mem_addr = sel_addr;
  assign bus.mem_in   = sel_wdata;
  assign bus.mem_load = sel_we && (sel_addr[14:13] != 2'b11);

  assign bus.a_gnt    = gnt_a;
  assign bus.b_gnt    = gnt_b;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      last       <= 1'b1;
      cnt        <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= gnt_a && !bus.a_we;
      b_rvalid_q <= gnt_b && !bus.b_we;
      if (gnt_a && !bus.a_we) a_rdata_q <= bus.mem_out;
      if (gnt_b && !bus.b_we) b_rdata_q <= bus.mem_out;

      if (gnt_a)      last <= 1'b0;
      else if (gnt_b) last <= 1'b1;

      case (state)
        ARB: begin
          if (LOCK_EN && gnt_a && bus.a_lock) begin
            state <= OWN_A;
            cnt   <= CW'(1);
          end else if (LOCK_EN && gnt_b && bus.b_lock) begin
            state <= OWN_B;
            cnt   <= CW'(1);
          end
        end
        OWN_A: begin
          if (bus.a_req && bus.a_lock && cnt_inc != CW'(MAX_BURST)) begin
            cnt <= cnt_inc;
          end else begin
            state <= ARB;
            cnt   <= '0;
          end
        end
        OWN_B: begin
          if (bus.b_req && bus.b_lock && cnt_inc != CW'(MAX_BURST)) begin
            cnt <= cnt_inc;
          end else begin
            state <= ARB;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ARB;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios then random traffic, checked
// every cycle against a requester-level arbitration model and a shadow memory.
module tb_memory_arbiter;

  localparam int MB = 4;

  logic clk;
  logic rst_n;

  memory_arbiter_if ifc();

  memory_arbiter #(.MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];

  assign ifc.mem_out = mem[ifc.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: owner/last use 0 = none, 1 = A, 2 = B
  int          m_owner;
  int          m_used;
  int          m_last;
  logic        exp_a_rv, exp_b_rv;
  logic [15:0] exp_a_rd, exp_b_rd;

  logic        obs_a_gnt, obs_b_gnt, obs_load;
  logic [14:0] obs_addr;
  logic [15:0] obs_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_used   = 0;
    m_last   = 2;
    exp_a_rv = 1'b0;
    exp_b_rv = 1'b0;
    exp_a_rd = 16'h0;
    exp_b_rd = 16'h0;
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock,
                       input logic [14:0] addr, input logic [15:0] wdata);
    ifc.a_req = req; ifc.a_we = we; ifc.a_lock = lock;
    ifc.a_addr = addr; ifc.a_wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock,
                       input logic [14:0] addr, input logic [15:0] wdata);
    ifc.b_req = req; ifc.b_we = we; ifc.b_lock = lock;
    ifc.b_addr = addr; ifc.b_wdata = wdata;
  endtask

  // One clock cycle: inputs already applied after a falling edge.
  task automatic step();
    int          w;
    int          prev_owner;
    logic        w_lock;
    logic [14:0] e_addr;
    logic [15:0] e_in;
    logic        e_we, e_load;
    logic        n_a_rv, n_b_rv;
    logic [15:0] n_a_rd, n_b_rd;
    #1;
    prev_owner = m_owner;
    if (m_owner == 1 && ifc.a_req)      w = 1;
    else if (m_owner == 2 && ifc.b_req) w = 2;
    else if (ifc.a_req && ifc.b_req)    w = (m_last == 1) ? 2 : 1;
    else if (ifc.a_req)                 w = 1;
    else if (ifc.b_req)                 w = 2;
    else                                w = 0;

    e_addr = 15'h0; e_in = 16'h0; e_we = 1'b0; w_lock = 1'b0;
    if (w == 1) begin e_addr = ifc.a_addr; e_in = ifc.a_wdata; e_we = ifc.a_we; w_lock = ifc.a_lock; end
    if (w == 2) begin e_addr = ifc.b_addr; e_in = ifc.b_wdata; e_we = ifc.b_we; w_lock = ifc.b_lock; end
    e_load = e_we && (e_addr < 15'h6000);

    obs_a_gnt = ifc.a_gnt;
    obs_b_gnt = ifc.b_gnt;
    obs_load  = ifc.mem_load;
    obs_addr  = ifc.mem_addr;
    obs_in    = ifc.mem_in;

    chk("a_gnt",    obs_a_gnt, (w == 1));
    chk("b_gnt",    obs_b_gnt, (w == 2));
    chk("mem_addr", obs_addr,  e_addr);
    chk("mem_in",   obs_in,    e_in);
    chk("mem_load", obs_load,  e_load);
    chk("a_rvalid", ifc.a_rvalid, exp_a_rv);
    chk("a_rdata",  ifc.a_rdata,  exp_a_rd);
    chk("b_rvalid", ifc.b_rvalid, exp_b_rv);
    chk("b_rdata",  ifc.b_rdata,  exp_b_rd);

    if (w != 0 && w == prev_owner) begin
      m_used++;
      if (!w_lock || m_used >= MB) begin m_owner = 0; m_used = 0; end
    end else if (prev_owner != 0) begin
      m_owner = 0; m_used = 0;
    end else if (w != 0 && w_lock && MB > 1) begin
      m_owner = w; m_used = 1;
    end

    n_a_rv = (w == 1) && !ifc.a_we;
    n_b_rv = (w == 2) && !ifc.b_we;
    n_a_rd = n_a_rv ? ref_mem[ifc.a_addr] : exp_a_rd;
    n_b_rd = n_b_rv ? ref_mem[ifc.b_addr] : exp_b_rd;
    if (w != 0) m_last = w;
    if (e_load) ref_mem[e_addr] = e_in;

    @(posedge clk);
    #1;
    if (obs_load) mem[obs_addr] = obs_in;
    exp_a_rv = n_a_rv; exp_b_rv = n_b_rv;
    exp_a_rd = n_a_rd; exp_b_rd = n_b_rd;
    @(negedge clk);
  endtask

  initial begin
    int          a_gnts;
    logic        a_wait, b_wait;
    logic [14:0] addr_r;

    for (int i = 0; i < 32768; i++) begin
      mem[i]     = (i >= 16'h6000) ? 16'h0F0F : (16'(i) ^ 16'hA5A5);
      ref_mem[i] = mem[i];
    end
    model_reset();

    rst_n = 1'b0;
    set_a(1'b1, 1'b1, 1'b1, 15'h0123, 16'hBEEF);
    set_b(1'b1, 1'b1, 1'b0, 15'h0456, 16'hCAFE);
    @(posedge clk);
    #1;
    chk("rst_a_gnt",    ifc.a_gnt,    1'b0);
    chk("rst_b_gnt",    ifc.b_gnt,    1'b0);
    chk("rst_mem_load", ifc.mem_load, 1'b0);
    chk("rst_mem_addr", ifc.mem_addr, 15'h0);
    chk("rst_mem_in",   ifc.mem_in,   16'h0);
    chk("rst_a_rvalid", ifc.a_rvalid, 1'b0);
    chk("rst_b_rdata",  ifc.b_rdata,  16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // A write then read-back
    set_b(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    set_a(1'b1, 1'b1, 1'b0, 15'h0010, 16'h1234);
    step();
    chk("wr_a_gnt", obs_a_gnt, 1'b1);
    set_a(1'b1, 1'b0, 1'b0, 15'h0010, 16'h0);
    step();
    chk("rd_a_gnt", obs_a_gnt, 1'b1);
    chk("rd_a_rvalid", ifc.a_rvalid, 1'b1);
    chk("rd_a_rdata",  ifc.a_rdata,  16'h1234);

    // round-robin reads under continuous contention
    set_a(1'b1, 1'b0, 1'b0, 15'h0020, 16'h0);
    set_b(1'b1, 1'b0, 1'b0, 15'h0030, 16'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_alternate", obs_b_gnt, (i % 2 == 0));
    end

    // locked burst of MB cycles by A, then B
    set_a(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    step();
    set_b(1'b1, 1'b0, 1'b0, 15'h0031, 16'h0);
    step();
    set_a(1'b1, 1'b0, 1'b1, 15'h0040, 16'h0);
    a_gnts = 0;
    for (int i = 0; i < MB; i++) begin
      step();
      if (obs_a_gnt) a_gnts++;
    end
    chk("burst_len", a_gnts, MB);
    step();
    chk("burst_then_b", obs_b_gnt, 1'b1);

    // burst with lock dropped on its second cycle
    set_a(1'b1, 1'b0, 1'b1, 15'h0041, 16'h0);
    step();
    chk("drop_c1_a", obs_a_gnt, 1'b1);
    set_a(1'b1, 1'b0, 1'b0, 15'h0041, 16'h0);
    step();
    chk("drop_c2_a", obs_a_gnt, 1'b1);
    step();
    chk("drop_c3_b", obs_b_gnt, 1'b1);

    // screen write and keyboard write protect
    set_a(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    set_b(1'b1, 1'b1, 1'b0, 15'h4000, 16'hFFFF);
    step();
    set_b(1'b1, 1'b0, 1'b0, 15'h4000, 16'h0);
    step();
    chk("screen_rdata", ifc.b_rdata, 16'hFFFF);
    set_b(1'b1, 1'b1, 1'b0, 15'h6000, 16'h1111);
    step();
    chk("kbd_b_gnt",    obs_b_gnt, 1'b1);
    chk("kbd_mem_load", obs_load,  1'b0);
    set_b(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    set_a(1'b1, 1'b0, 1'b0, 15'h6000, 16'h0);
    step();
    chk("kbd_rdata", ifc.a_rdata, 16'h0F0F);

    // random traffic; a waiting requester holds its request unchanged
    a_wait = 1'b0;
    b_wait = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!a_wait) begin
        addr_r = {2'($urandom_range(0, 3)), 9'h0, 4'($urandom_range(0, 15))};
        set_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              addr_r, 16'($urandom));
      end
      if (!b_wait) begin
        addr_r = {2'($urandom_range(0, 3)), 9'h0, 4'($urandom_range(0, 15))};
        set_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              addr_r, 16'($urandom));
      end
      step();
      a_wait = ifc.a_req && !obs_a_gnt;
      b_wait = ifc.b_req && !obs_b_gnt;
    end

    // reset during an A locked read burst
    set_a(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    set_b(1'b0, 1'b0, 1'b0, 15'h0, 16'h0);
    step();
    step();
    set_a(1'b1, 1'b0, 1'b1, 15'h0050, 16'h0);
    step();
    set_b(1'b1, 1'b0, 1'b0, 15'h0060, 16'h0);
    step();
    chk("preburst_a_gnt", obs_a_gnt, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_a_gnt",    ifc.a_gnt,    1'b0);
    chk("midrst_mem_load", ifc.mem_load, 1'b0);
    chk("midrst_a_rvalid", ifc.a_rvalid, 1'b0);
    chk("midrst_a_rdata",  ifc.a_rdata,  16'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_a(1'b1, 1'b0, 1'b0, 15'h0051, 16'h0);
    set_b(1'b1, 1'b0, 1'b0, 15'h0061, 16'h0);
    step();
    chk("post_rst_a_first", obs_a_gnt, 1'b1);
    step();
    chk("post_rst_b_next", obs_b_gnt, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
